// File: rtl/uart_8250_pkg.sv
// Shared definitions for the 8250-compatible UART: LCR bit positions, FSM encoding,
// oversampling constant and the frame helpers used by the TX and RX controllers.
package uart_8250_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    localparam int LCR_WLS_LSB = 0;
    localparam int LCR_WLS_MSB = 1;
    localparam int LCR_STB     = 2;
    localparam int LCR_PEN     = 3;
    localparam int LCR_EPS     = 4;
    localparam int LCR_STICK   = 5;
    localparam int LCR_BRK     = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef struct packed {
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       parity;
    } frame_cfg_t;

    // Parity only covers the active word bits; stick parity forces the inverse of EPS.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       eps,
                                        input logic       stick);
        logic [7:0] active;
        active = data & (8'hFF >> (2'd3 - wls));
        if (stick)
            return ~eps;
        else if (eps)
            return ^active;
        else
            return ~^active;
    endfunction

    // Index of the final stop tick: 1, 1.5 or 2 stop bits.
    function automatic logic [4:0] stop_last_tick(input logic [1:0] wls, input logic stb);
        if (!stb)
            return 5'd15;
        else if (wls == 2'd0)
            return 5'd23;
        else
            return 5'd31;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x baud tick generator: counts divisor-1 down to 0 and ticks on 0.
// A reload restarts the count so each bit is exactly OVERSAMPLE*divisor clocks.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [DIV_W-1:0] divisor,
    input  logic             reload,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic             halted;

    assign halted = (divisor == '0);

    // A divisor of zero freezes the count, so nothing downstream advances.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            count <= '0;
        end else if (!halted) begin
            if (reload || (count == '0))
                count <= divisor - DIV_W'(1);
            else
                count <= count - DIV_W'(1);
        end
    end

    assign tick = !halted && !reload && (count == '0);

endmodule

// File: rtl/uart_8250_tx_ctrl.sv
// 8250 transmit sequencer: pops the TX FIFO, frames each byte per the shadowed LCR
// and shifts it out on TXD, reporting busy/empty/done status to the register file.
module uart_8250_tx_ctrl
    import uart_8250_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [DIV_W-1:0] divisor,
    input  logic [7:0]       lcr,
    input  logic             tx_empty,
    input  logic [7:0]       tx_data,
    output logic             tx_pop,
    output logic             TXD,
    output logic             tsr_busy,
    output logic             temt,
    output logic             frame_done
);

    localparam logic [4:0] LAST_OS_TICK = 5'(OVERSAMPLE - 1);

    logic [2:0] state;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic [4:0] tick_cnt;
    frame_cfg_t cfg;
    logic       ready;
    logic       tick;
    logic       bit_end;
    logic       stop_end;
    logic       start_frame;
    logic       line_bit;
    logic [2:0] last_bit;
    logic       unused_lcr;

    assign unused_lcr = lcr[7];

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .divisor (divisor),
        .reload  (start_frame),
        .tick    (tick)
    );

    // Holds off the first pop until one clock after reset release.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I)
            ready <= 1'b0;
        else
            ready <= 1'b1;
    end

    assign start_frame = ready && (state == ST_IDLE) && !tx_empty && (divisor != '0);
    assign tx_pop      = start_frame;
    assign bit_end     = tick && (tick_cnt == LAST_OS_TICK);
    assign stop_end    = tick && (tick_cnt == stop_last_tick(cfg.wls, cfg.stb));
    assign last_bit    = 3'd4 + {1'b0, cfg.wls};

    // Frame sequencer; everything but break comes from the shadow copy taken at pop.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tick_cnt  <= '0;
            cfg       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        shift_reg  <= tx_data;
                        cfg.wls    <= lcr[LCR_WLS_MSB:LCR_WLS_LSB];
                        cfg.stb    <= lcr[LCR_STB];
                        cfg.pen    <= lcr[LCR_PEN];
                        cfg.parity <= parity_bit(tx_data, lcr[LCR_WLS_MSB:LCR_WLS_LSB],
                                                 lcr[LCR_EPS], lcr[LCR_STICK]);
                        bit_idx    <= '0;
                        tick_cnt   <= '0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= ST_DATA;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 5'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        tick_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == last_bit) begin
                            bit_idx <= '0;
                            state   <= cfg.pen ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 5'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= ST_STOP;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 5'd1;
                    end
                end
                ST_STOP: begin
                    if (stop_end) begin
                        tick_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 5'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        line_bit = 1'b1;
        case (state)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shift_reg[0];
            ST_PARITY: line_bit = cfg.parity;
            default:   line_bit = 1'b1;
        endcase
    end

    // Break is live from the register, overriding the line without touching frame timing.
    assign TXD        = lcr[LCR_BRK] ? 1'b0 : line_bit;
    assign tsr_busy   = (state != ST_IDLE);
    assign temt       = tx_empty && !tsr_busy;
    assign frame_done = (state == ST_STOP) && stop_end;

endmodule

// File: tb/tb_uart_8250_tx_ctrl.sv
// Self-checking bench for uart_8250_tx_ctrl: a FIFO model feeds the DUT and each frame's
// TXD waveform is compared clock by clock against a waveform built from the framing rules.
module tb_uart_8250_tx_ctrl;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [15:0] divisor;
    logic [7:0]  lcr;
    logic        tx_empty;
    logic [7:0]  tx_data;
    logic        tx_pop;
    logic        TXD;
    logic        tsr_busy;
    logic        temt;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_mem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       pop_pend;

    bit exp_wave[$];
    bit obs_txd[$];
    bit obs_done[$];
    bit obs_temt[$];

    uart_8250_tx_ctrl dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .divisor    (divisor),
        .lcr        (lcr),
        .tx_empty   (tx_empty),
        .tx_data    (tx_data),
        .tx_pop     (tx_pop),
        .TXD        (TXD),
        .tsr_busy   (tsr_busy),
        .temt       (temt),
        .frame_done (frame_done)
    );

    always #5 CLK_I = ~CLK_I;

    // First-word-fall-through FIFO model; the head advances half a clock after a pop edge.
    assign tx_empty = (rd_ptr == wr_ptr);
    assign tx_data  = fifo_mem[rd_ptr[5:0]];

    always @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I)
            pop_pend <= 1'b0;
        else
            pop_pend <= tx_pop;
    end

    always @(negedge CLK_I) begin
        if (pop_pend)
            rd_ptr <= rd_ptr + 1;
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    // Expected TXD for every clock after the pop cycle up to the final stop clock.
    task automatic build_wave(input logic [7:0] d, input logic [7:0] l, input int div);
        int         nbits;
        int         bw;
        int         stop_t;
        int         ones;
        bit         p;
        logic [7:0] act;
        exp_wave.delete();
        nbits = 5 + int'(l[1:0]);
        bw    = 16 * div;
        repeat (bw) exp_wave.push_back(1'b0);
        for (int i = 0; i < nbits; i++)
            repeat (bw) exp_wave.push_back(d[i]);
        if (l[3]) begin
            act  = d & 8'((1 << nbits) - 1);
            ones = $countones(act);
            if (l[5])
                p = ~l[4];
            else if (l[4])
                p = (ones % 2 == 1);
            else
                p = (ones % 2 == 0);
            repeat (bw) exp_wave.push_back(p);
        end
        stop_t = !l[2] ? 16 : ((nbits == 5) ? 24 : 32);
        repeat (stop_t * div) exp_wave.push_back(1'b1);
    endtask

    task automatic capture(input int n);
        obs_txd.delete();
        obs_done.delete();
        obs_temt.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_I);
            obs_txd.push_back(TXD);
            obs_done.push_back(frame_done);
            obs_temt.push_back(temt);
        end
    endtask

    task automatic wait_pop(input int limit, output bit seen);
        seen = 1'b0;
        #1;
        for (int n = 0; n < limit && !seen; n++) begin
            if (tx_pop === 1'b1)
                seen = 1'b1;
            else
                @(negedge CLK_I);
        end
    endtask

    function automatic int first_txd_diff();
        for (int i = 0; i < exp_wave.size(); i++)
            if (obs_txd[i] !== exp_wave[i]) return i;
        return -1;
    endfunction

    function automatic int done_index();
        int idx = -1;
        for (int i = 0; i < obs_done.size(); i++) begin
            if (obs_done[i]) begin
                if (idx >= 0) return -2;
                idx = i;
            end
        end
        return idx;
    endfunction

    task automatic test_reset();
        RST_I   = 1'b0;
        divisor = 16'd1;
        lcr     = 8'h03;
        repeat (3) @(negedge CLK_I);
        total++;
        if (TXD !== 1'b1) begin bad++; $display("[TB] FAIL reset_txd: got %b want 1", TXD); end
        total++;
        if (tx_pop !== 1'b0) begin bad++; $display("[TB] FAIL reset_pop: got %b want 0", tx_pop); end
        total++;
        if (tsr_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", tsr_busy); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", frame_done); end
        total++;
        if (temt !== 1'b1) begin bad++; $display("[TB] FAIL reset_temt: got %b want 1", temt); end
        RST_I = 1'b1;
        repeat (2) @(negedge CLK_I);
        total++;
        if (tsr_busy !== 1'b0 || TXD !== 1'b1)
            begin bad++; $display("[TB] FAIL reset_release: busy=%b TXD=%b want 0/1", tsr_busy, TXD); end
    endtask

    task automatic test_basic();
        bit seen;
        int d;
        int di;
        divisor = 16'd1;
        lcr     = 8'h03;
        @(negedge CLK_I);
        push_byte(8'h55);
        wait_pop(20, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL basic_pop: no pop within 20 clocks"); end
        build_wave(8'h55, 8'h03, 1);
        capture(exp_wave.size());
        d = first_txd_diff();
        total++;
        if (d >= 0)
            begin bad++; $display("[TB] FAIL basic_wave: clock %0d TXD=%b want %b", d + 1, obs_txd[d], exp_wave[d]); end
        di = done_index();
        total++;
        if (di != 159) begin bad++; $display("[TB] FAIL basic_done: index %0d want 159", di); end
        @(negedge CLK_I);
        total++;
        if (tsr_busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_end: got %b want 0", tsr_busy); end
        total++;
        if (temt !== 1'b1) begin bad++; $display("[TB] FAIL basic_temt_end: got %b want 1", temt); end
    endtask

    task automatic test_parity_8e1();
        bit seen;
        int d;
        int di;
        divisor = 16'd2;
        lcr     = 8'h1B;
        @(negedge CLK_I);
        push_byte(8'hA7);
        wait_pop(20, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL p8e1_pop: no pop within 20 clocks"); end
        build_wave(8'hA7, 8'h1B, 2);
        capture(exp_wave.size());
        d = first_txd_diff();
        total++;
        if (d >= 0)
            begin bad++; $display("[TB] FAIL p8e1_wave: clock %0d TXD=%b want %b", d + 1, obs_txd[d], exp_wave[d]); end
        total++;
        if (obs_txd[9 * 32 + 16] !== 1'b1)
            begin bad++; $display("[TB] FAIL p8e1_parity: got %b want 1", obs_txd[9 * 32 + 16]); end
        di = done_index();
        total++;
        if (di != 351) begin bad++; $display("[TB] FAIL p8e1_done: index %0d want 351", di); end
    endtask

    task automatic test_stop_len();
        bit         seen;
        int         d;
        int         di;
        logic [7:0] lcrs [2] = '{8'h04, 8'h07};
        int         want [2] = '{119, 175};
        divisor = 16'd1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK_I);
            lcr = lcrs[k];
            push_byte(8'h1F);
            wait_pop(20, seen);
            total++;
            if (!seen) begin bad++; $display("[TB] FAIL stop_pop: frame %0d no pop", k); end
            build_wave(8'h1F, lcrs[k], 1);
            capture(exp_wave.size());
            d = first_txd_diff();
            total++;
            if (d >= 0)
                begin bad++; $display("[TB] FAIL stop_wave: lcr %h clock %0d TXD=%b want %b", lcrs[k], d + 1, obs_txd[d], exp_wave[d]); end
            di = done_index();
            total++;
            if (di != want[k]) begin bad++; $display("[TB] FAIL stop_done: lcr %h index %0d want %0d", lcrs[k], di, want[k]); end
        end
    endtask

    task automatic test_back_to_back();
        bit         seen;
        int         d;
        int         di;
        int         temt_hi;
        int         start_rd;
        logic [7:0] vals [3] = '{8'h31, 8'hC4, 8'h0F};
        divisor = 16'd1;
        lcr     = 8'h03;
        @(negedge CLK_I);
        start_rd = rd_ptr;
        for (int k = 0; k < 3; k++) push_byte(vals[k]);
        wait_pop(20, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL b2b_pop: no first pop"); end
        for (int k = 0; k < 3; k++) begin
            build_wave(vals[k], 8'h03, 1);
            capture(exp_wave.size());
            d = first_txd_diff();
            total++;
            if (d >= 0)
                begin bad++; $display("[TB] FAIL b2b_wave: frame %0d clock %0d TXD=%b want %b", k, d + 1, obs_txd[d], exp_wave[d]); end
            di = done_index();
            total++;
            if (di != 159) begin bad++; $display("[TB] FAIL b2b_done: frame %0d index %0d want 159", k, di); end
            temt_hi = 0;
            foreach (obs_temt[i]) if (obs_temt[i]) temt_hi++;
            total++;
            if (temt_hi != 0) begin bad++; $display("[TB] FAIL b2b_temt_busy: frame %0d temt high %0d clocks want 0", k, temt_hi); end
            @(negedge CLK_I);
            if (k < 2) begin
                total++;
                if (tx_pop !== 1'b1 || temt !== 1'b0)
                    begin bad++; $display("[TB] FAIL b2b_gap: frame %0d pop=%b temt=%b want 1/0", k, tx_pop, temt); end
            end else begin
                total++;
                if (tx_pop !== 1'b0 || temt !== 1'b1)
                    begin bad++; $display("[TB] FAIL b2b_final: pop=%b temt=%b want 0/1", tx_pop, temt); end
            end
        end
        repeat (2) @(negedge CLK_I);
        total++;
        if (rd_ptr - start_rd != 3) begin bad++; $display("[TB] FAIL b2b_pops: got %0d want 3", rd_ptr - start_rd); end
    endtask

    task automatic test_break();
        bit seen;
        bit in_brk;
        bit want;
        int d;
        int di;
        divisor = 16'd1;
        lcr     = 8'h03;
        @(negedge CLK_I);
        push_byte(8'hB6);
        wait_pop(20, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL brk_pop: no pop"); end
        build_wave(8'hB6, 8'h03, 1);
        in_brk = 1'b0;
        d      = -1;
        di     = -1;
        for (int i = 0; i < exp_wave.size(); i++) begin
            @(negedge CLK_I);
            want = in_brk ? 1'b0 : exp_wave[i];
            if (TXD !== want && d < 0) d = i;
            if (frame_done === 1'b1 && di == -1) di = i;
            if (i == 40) begin
                lcr = 8'h43;
                #1;
                total++;
                if (TXD !== 1'b0) begin bad++; $display("[TB] FAIL brk_immediate: TXD=%b want 0", TXD); end
                in_brk = 1'b1;
            end
            if (i == 90) begin
                lcr    = 8'h03;
                in_brk = 1'b0;
            end
        end
        total++;
        if (d >= 0) begin bad++; $display("[TB] FAIL brk_wave: clock %0d mismatch, TXD=%b", d + 1, TXD); end
        total++;
        if (di != 159) begin bad++; $display("[TB] FAIL brk_done: index %0d want 159", di); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        int d;
        int di;
        divisor = 16'd1;
        lcr     = 8'h03;
        @(negedge CLK_I);
        push_byte(8'h00);
        push_byte(8'h5A);
        wait_pop(20, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL abort_pop: no pop"); end
        repeat (5) @(negedge CLK_I);
        total++;
        if (TXD !== 1'b0) begin bad++; $display("[TB] FAIL abort_start: TXD=%b want 0", TXD); end
        #2;
        RST_I = 1'b0;
        #1;
        total++;
        if (TXD !== 1'b1) begin bad++; $display("[TB] FAIL abort_txd: TXD=%b want 1", TXD); end
        total++;
        if (tsr_busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", tsr_busy); end
        total++;
        if (tx_pop !== 1'b0) begin bad++; $display("[TB] FAIL abort_pop_in_reset: got %b want 0", tx_pop); end
        @(negedge CLK_I);
        RST_I = 1'b1;
        wait_pop(20, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL abort_repop: no pop after release"); end
        build_wave(8'h5A, 8'h03, 1);
        capture(exp_wave.size());
        d = first_txd_diff();
        total++;
        if (d >= 0)
            begin bad++; $display("[TB] FAIL abort_wave: clock %0d TXD=%b want %b", d + 1, obs_txd[d], exp_wave[d]); end
        di = done_index();
        total++;
        if (di != 159) begin bad++; $display("[TB] FAIL abort_done: index %0d want 159", di); end
    endtask

    task automatic test_div_zero();
        bit seen;
        bit pop_seen;
        bit txd_low;
        int d;
        divisor = 16'd0;
        lcr     = 8'h03;
        @(negedge CLK_I);
        push_byte(8'h96);
        pop_seen = 1'b0;
        txd_low  = 1'b0;
        repeat (50) begin
            @(negedge CLK_I);
            if (tx_pop !== 1'b0) pop_seen = 1'b1;
            if (TXD !== 1'b1) txd_low = 1'b1;
        end
        total++;
        if (pop_seen) begin bad++; $display("[TB] FAIL div0_pop: pop seen with divisor 0"); end
        total++;
        if (txd_low) begin bad++; $display("[TB] FAIL div0_txd: TXD left idle with divisor 0"); end
        total++;
        if (temt !== 1'b0) begin bad++; $display("[TB] FAIL div0_temt: got %b want 0", temt); end
        divisor = 16'd1;
        wait_pop(20, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL div0_resume_pop: no pop after divisor set"); end
        build_wave(8'h96, 8'h03, 1);
        capture(exp_wave.size());
        d = first_txd_diff();
        total++;
        if (d >= 0)
            begin bad++; $display("[TB] FAIL div0_wave: clock %0d TXD=%b want %b", d + 1, obs_txd[d], exp_wave[d]); end
    endtask

    task automatic test_random();
        bit         seen;
        int         d;
        int         di;
        int         div;
        logic [7:0] b;
        logic [7:0] l;
        for (int f = 0; f < 8; f++) begin
            b   = 8'($urandom);
            l   = {2'b00, 6'($urandom)};
            div = int'($urandom_range(1, 3));
            @(negedge CLK_I);
            divisor = 16'(div);
            lcr     = l;
            push_byte(b);
            wait_pop(20, seen);
            total++;
            if (!seen) begin bad++; $display("[TB] FAIL rand_pop: frame %0d no pop", f); end
            @(posedge CLK_I);
            #1;
            lcr = {2'b00, 6'($urandom)};
            build_wave(b, l, div);
            capture(exp_wave.size());
            d = first_txd_diff();
            total++;
            if (d >= 0)
                begin bad++; $display("[TB] FAIL rand_wave: data %h lcr %h div %0d clock %0d TXD=%b want %b", b, l, div, d + 1, obs_txd[d], exp_wave[d]); end
            di = done_index();
            total++;
            if (di != exp_wave.size() - 1)
                begin bad++; $display("[TB] FAIL rand_done: data %h lcr %h div %0d index %0d want %0d", b, l, div, di, exp_wave.size() - 1); end
        end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity_8e1();
        test_stop_len();
        test_back_to_back();
        test_break();
        test_reset_abort();
        test_div_zero();
        test_random();
        repeat (4) @(negedge CLK_I);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
